// File: rtl/eq_coe_scheduler.sv
// Coefficient-load controller for the 3-band IIR equalizer.
// Key decode, per-band dirty flags, round-robin ROM streaming.
module eq_coe_scheduler #(
  parameter int NUM_BANDS = 3,
  parameter int NUM_COE   = 6,
  parameter int COE_W     = 17,
  parameter int LVL_MAX   = 20,
  parameter int LVL_DEF   = 10
) (
  input  logic                          ws,
  input  logic                          sys_rst,
  input  logic [2:0]                    coe_ctrl,
  output logic [8:0]                    rom_addr,
  input  logic signed [COE_W-1:0]       rom_q,
  output logic signed [COE_W-1:0]       coe_data,
  output logic [NUM_BANDS-1:0]          coe_en,
  output logic [5*NUM_BANDS-1:0]        band_lvl,
  output logic                          busy
);

  localparam logic [4:0] LMAX = 5'(LVL_MAX);
  localparam logic [4:0] LDEF = 5'(LVL_DEF);
  localparam logic [2:0] KMAX = 3'(NUM_COE - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [2:0]                   k_q, k_d;
  logic [4:0]                   snap_q, snap_d;
  logic [1:0]                   grant_q, grant_d;
  logic [1:0]                   pick;
  logic                         found;
  logic [NUM_BANDS-1:0]         dirty_q;
  logic [NUM_BANDS-1:0]         clr_dirty;
  logic [NUM_BANDS-1:0]         set_dirty;
  logic [NUM_BANDS-1:0][4:0]    lvl_q, lvl_n;
  logic [2:0]                   cmd_hold;
  logic                         exec;

  always_comb begin
    lvl_n     = lvl_q;
    set_dirty = '0;
    exec      = (coe_ctrl == 3'b000) && (cmd_hold != 3'b000);
    if (exec) begin
      if (cmd_hold == 3'b111) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          lvl_n[b] = LDEF;
        end
        set_dirty = '1;
      end else begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          if (cmd_hold == 3'(2*b + 1) && lvl_q[b] != LMAX) begin
            lvl_n[b]     = lvl_q[b] + 5'd1;
            set_dirty[b] = 1'b1;
          end
          if (cmd_hold == 3'(2*b + 2) && lvl_q[b] != 5'd0) begin
            lvl_n[b]     = lvl_q[b] - 5'd1;
            set_dirty[b] = 1'b1;
          end
        end
      end
    end
  end

  // Descending scan so the nearest dirty band after grant_q wins.
  always_comb begin
    pick  = grant_q;
    found = 1'b0;
    for (int j = NUM_BANDS; j >= 1; j--) begin
      for (int b = 0; b < NUM_BANDS; b++) begin
        if (dirty_q[b] && ((int'(grant_q) + j) % NUM_BANDS == b)) begin
          pick  = 2'(b);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    snap_d    = snap_q;
    grant_d   = grant_q;
    clr_dirty = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOAD;
          k_d     = 3'd0;
          snap_d  = lvl_q[pick];
          grant_d = pick;
          for (int b = 0; b < NUM_BANDS; b++) begin
            clr_dirty[b] = (pick == 2'(b));
          end
        end
      end
      LOAD: begin
        k_d = k_q + 3'd1;
        if (k_q == KMAX) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ws) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      k_q      <= 3'd0;
      snap_q   <= 5'd0;
      grant_q  <= 2'(NUM_BANDS - 1);
      dirty_q  <= '1;
      lvl_q    <= {NUM_BANDS{LDEF}};
      cmd_hold <= 3'b000;
      coe_en   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      snap_q   <= snap_d;
      grant_q  <= grant_d;
      dirty_q  <= (dirty_q & ~clr_dirty) | set_dirty;
      lvl_q    <= lvl_n;
      // Zero input both executes and clears the held code.
      cmd_hold <= coe_ctrl;
      coe_en   <= (state_q == LOAD) ? (NUM_BANDS'(1) << grant_q) : '0;
    end
  end

  assign rom_addr = (state_q == LOAD)
                  ? {grant_q, 7'(snap_q) * 7'd6 + 7'(k_q)}
                  : 9'd0;
  assign coe_data = rom_q;
  assign band_lvl = lvl_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_eq_coe_scheduler.sv
// Bench for eq_coe_scheduler: timeline reference model,
// command table, directed corner sequences, random keys.
module tb_eq_coe_scheduler;

  logic               ws = 1'b0;
  logic               sys_rst;
  logic [2:0]         coe_ctrl;
  logic [8:0]         rom_addr;
  logic signed [16:0] rom_q;
  logic signed [16:0] coe_data;
  logic [2:0]         coe_en;
  logic [14:0]        band_lvl;
  logic               busy;

  eq_coe_scheduler dut (
    .ws       (ws),
    .sys_rst  (sys_rst),
    .coe_ctrl (coe_ctrl),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .coe_data (coe_data),
    .coe_en   (coe_en),
    .band_lvl (band_lvl),
    .busy     (busy)
  );

  always #5 ws = ~ws;

  function automatic logic signed [16:0] rom_f(input logic [8:0] a);
    return 17'((int'(a) * 613) ^ 'h1555);
  endfunction

  function automatic logic [8:0] addr_of(input int b, input int l,
                                         input int k);
    return 9'(b * 128 + l * 6 + k);
  endfunction

  always @(posedge ws) rom_q <= rom_f(rom_addr);

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: levels, pending set and the current grant time.
  int   m_lvl[3];
  bit   m_dirty[3];
  int   m_last, m_free, m_g, m_gb, m_gl;
  logic [2:0] m_prev;
  int   mcyc = 0;
  bit   m_rst_prev = 1'b1;

  int         en_cnt = 0;
  bit         en_prev = 1'b0;
  logic [8:0] addr_prev = '0;
  logic [8:0] obs_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               name, mcyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_lvl[b]   = 10;
      m_dirty[b] = 1'b1;
    end
    m_last = 2;
    m_g    = -100;
    m_prev = 3'b000;
  endtask

  task automatic model_exec(input logic [2:0] c);
    int b, nl;
    if (c == 3'b111) begin
      for (int i = 0; i < 3; i++) begin
        m_lvl[i]   = 10;
        m_dirty[i] = 1'b1;
      end
    end else begin
      b  = (int'(c) - 1) / 2;
      nl = c[0] ? m_lvl[b] + 1 : m_lvl[b] - 1;
      if (nl > 20) nl = 20;
      if (nl < 0) nl = 0;
      if (nl != m_lvl[b]) begin
        m_lvl[b]   = nl;
        m_dirty[b] = 1'b1;
      end
    end
  endtask

  task automatic model_step(input logic [2:0] c, input logic r);
    int b;
    if (r) begin
      model_reset();
      m_free     = mcyc + 1;
      m_rst_prev = 1'b1;
    end else begin
      m_rst_prev = 1'b0;
      if (mcyc >= m_free) begin
        for (int j = 1; j <= 3; j++) begin
          b = (m_last + j) % 3;
          if (m_dirty[b]) begin
            m_g        = mcyc;
            m_gb       = b;
            m_gl       = m_lvl[b];
            m_dirty[b] = 1'b0;
            m_last     = b;
            m_free     = mcyc + 8;
            break;
          end
        end
      end
      if (c == 3'b000 && m_prev != 3'b000) model_exec(m_prev);
      m_prev = c;
    end
    mcyc++;
  endtask

  task automatic check_now();
    int d;
    logic [2:0]  exp_en;
    logic [14:0] exp_lvl;
    d      = mcyc - m_g;
    exp_en = (d >= 2 && d <= 7) ? 3'(1 << m_gb) : 3'b000;
    for (int b = 0; b < 3; b++) exp_lvl[5*b +: 5] = 5'(m_lvl[b]);
    chk("coe_en", 32'(coe_en), 32'(exp_en));
    chk("busy", 32'(busy), 32'(d >= 1 && d <= 7));
    chk("band_lvl", 32'(band_lvl), 32'(exp_lvl));
    if (d >= 1 && d <= 6)
      chk("rom_addr", 32'(rom_addr), 32'(addr_of(m_gb, m_gl, d - 1)));
    if (exp_en != 3'b000)
      chk("coe_data", 32'(coe_data),
          32'(rom_f(addr_of(m_gb, m_gl, d - 2))));
    if (m_rst_prev)
      chk("rom_addr_rst", 32'(rom_addr), 32'd0);
  endtask

  task automatic cycle(input logic [2:0] c, input logic r);
    coe_ctrl = c;
    sys_rst  = r;
    @(negedge ws);
    check_now();
    if (coe_en != 3'b000) en_cnt++;
    if (coe_en != 3'b000 && !en_prev) obs_q.push_back(addr_prev);
    en_prev   = (coe_en != 3'b000);
    addr_prev = rom_addr;
    model_step(c, r);
    @(posedge ws);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(3'b000, 1'b0);
  endtask

  task automatic press(input logic [2:0] c);
    cycle(c, 1'b0);
    cycle(c, 1'b0);
    idle(12);
  endtask

  typedef struct {
    logic [2:0] cmd;
    int         presses;
    int         band;
    int         lvl;
    int         loads;
    logic [8:0] last;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n0, base, budget;
    logic [8:0] exp_a[5];

    tbl[0] = '{3'b011,  1, 1, 11,  1, 9'h0C2};
    tbl[1] = '{3'b010, 11, 0,  0, 10, 9'h000};
    tbl[2] = '{3'b101,  2, 2, 12,  2, 9'h148};
    tbl[3] = '{3'b100,  1, 1, 10,  1, 9'h0BC};
    tbl[4] = '{3'b111,  1, 2, 10,  3, 9'h0BC};
    tbl[5] = '{3'b001, 25, 0, 20, 10, 9'h078};
    tbl[6] = '{3'b001,  1, 0, 20,  0, 9'h078};

    model_reset();
    m_free   = 0;
    sys_rst  = 1'b1;
    coe_ctrl = 3'b000;
    repeat (2) @(posedge ws);
    #1;

    // Reset release: defaults load in band order 0,1,2.
    cycle(3'b000, 1'b1);
    idle(30);
    chk("init_loads", 32'(obs_q.size()), 32'd3);
    exp_a = '{9'h03C, 9'h0BC, 9'h13C, 9'h000, 9'h000};
    for (int i = 0; i < 3 && i < obs_q.size(); i++)
      chk("init_addr", 32'(obs_q[i]), 32'(exp_a[i]));
    chk("init_idle", 32'(busy), 32'd0);

    for (int t = 0; t < 7; t++) begin
      n0 = obs_q.size();
      for (int p = 0; p < tbl[t].presses; p++) press(tbl[t].cmd);
      idle(20);
      chk("tbl_lvl", 32'(band_lvl[5*tbl[t].band +: 5]), 32'(tbl[t].lvl));
      chk("tbl_loads", 32'(obs_q.size() - n0), 32'(tbl[t].loads));
      if (obs_q.size() > 0)
        chk("tbl_last", 32'(obs_q[$]), 32'(tbl[t].last));
    end

    // Reset on the third strobe of a band1 load.
    cycle(3'b011, 1'b0);
    cycle(3'b011, 1'b0);
    en_cnt = 0;
    budget = 0;
    while (en_cnt < 2 && budget < 20) begin
      cycle(3'b000, 1'b0);
      budget++;
    end
    chk("rst_wait", 32'(en_cnt >= 2), 32'd1);
    chk("rst_en3", 32'(coe_en != 3'b000), 32'd1);
    cycle(3'b000, 1'b1);
    base = obs_q.size();
    chk("rst_en_off", 32'(coe_en), 32'd0);
    chk("rst_lvls", 32'(band_lvl), 32'({5'd10, 5'd10, 5'd10}));
    cycle(3'b000, 1'b0);
    idle(15);
    // Band2 up then band0 up while band2 loads its default.
    cycle(3'b101, 1'b0);
    cycle(3'b101, 1'b0);
    cycle(3'b000, 1'b0);
    cycle(3'b001, 1'b0);
    cycle(3'b001, 1'b0);
    idle(45);
    exp_a = '{9'h03C, 9'h0BC, 9'h13C, 9'h042, 9'h142};
    chk("coll_loads", 32'(obs_q.size() - base), 32'd5);
    for (int i = 0; i < 5 && base + i < obs_q.size(); i++)
      chk("coll_addr", 32'(obs_q[base + i]), 32'(exp_a[i]));
    chk("coll_lvls", 32'(band_lvl), 32'({5'd11, 5'd10, 5'd11}));

    for (int i = 0; i < 150; i++) begin
      logic [2:0] c;
      int hold, gap;
      c    = 3'($urandom_range(1, 7));
      hold = $urandom_range(1, 4);
      gap  = $urandom_range(0, 12);
      for (int h = 0; h < hold; h++) cycle(c, 1'b0);
      for (int g = 0; g < gap; g++)
        cycle(3'b000, ($urandom_range(0, 199) == 0));
    end
    idle(40);
    chk("final_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
